// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types for the SPI-to-RAM command sequencer.
// Frame commands, FSM states and default widths.
// Imported by the interface and the top module.
package spi_ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    TX      = 3'd4
  } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Bundle of the SPI-side, RAM-side and status signals of the sequencer.
// The slave modport is the controller's view, master is the surroundings.
// No logic, wires only.
interface spi_ram_ctrl_if #(
  parameter int ADDR_W = spi_ram_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = spi_ram_ctrl_pkg::DEF_DATA_W
);
  logic [ADDR_W+1:0] rx_data;
  logic              rx_valid;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_gnt;
  logic              ram_rvalid;
  logic [DATA_W-1:0] ram_rdata;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              err_seq;
  logic              err_ovf;

  modport slave (
    input  rx_data, rx_valid, ram_gnt, ram_rvalid, ram_rdata,
    output ram_req, ram_we, ram_addr, ram_wdata, tx_valid, tx_data,
           busy, err_seq, err_ovf
  );

  modport master (
    output rx_data, rx_valid, ram_gnt, ram_rvalid, ram_rdata,
    input  ram_req, ram_we, ram_addr, ram_wdata, tx_valid, tx_data,
           busy, err_seq, err_ovf
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI frames into RAM writes/reads and returns read data to the SPI side.
// rx_valid to ram_req: 1 cycle; ram_rvalid to tx_valid: 1 cycle.
// Frames arriving while an access is in flight are dropped and flagged (err_ovf).
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AUTO_INC = 1
) (
  input  logic            clk,
  input  logic            rst,
  spi_ram_ctrl_if.slave   bus
);

  state_e            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_addr_vld;

  cmd_e              rx_cmd;
  logic [ADDR_W-1:0] rx_pay;
  logic              in_flight;

  assign rx_cmd    = cmd_e'(bus.rx_data[ADDR_W+1:ADDR_W]);
  assign rx_pay    = bus.rx_data[ADDR_W-1:0];
  assign in_flight = (state == WR_REQ) || (state == RD_REQ) || (state == RD_WAIT);

  // busy follows the state register directly, so it drops with the async reset
  assign bus.busy = (state != IDLE);

  // Command FSM with registered RAM/TX outputs and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_addr       <= '0;
      rd_addr       <= '0;
      rd_addr_vld   <= 1'b0;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
      bus.err_seq   <= 1'b0;
      bus.err_ovf   <= 1'b0;
    end else begin
      if (bus.rx_valid && in_flight) begin
        bus.err_ovf <= 1'b1;
      end

      case (state)
        // TX behaves like IDLE once a new frame arrives: the frame releases tx_valid
        IDLE, TX: begin
          if (bus.rx_valid) begin
            bus.tx_valid <= 1'b0;
            state        <= IDLE;
            case (rx_cmd)
              WR_ADDR: wr_addr <= rx_pay;
              WR_DATA: begin
                bus.ram_req   <= 1'b1;
                bus.ram_we    <= 1'b1;
                bus.ram_addr  <= wr_addr;
                bus.ram_wdata <= DATA_W'(rx_pay);
                state         <= WR_REQ;
              end
              RD_ADDR: begin
                rd_addr     <= rx_pay;
                rd_addr_vld <= 1'b1;
              end
              RD_DATA: begin
                if (rd_addr_vld) begin
                  bus.ram_req  <= 1'b1;
                  bus.ram_we   <= 1'b0;
                  bus.ram_addr <= rd_addr;
                  state        <= RD_REQ;
                end else begin
                  bus.err_seq <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        WR_REQ: begin
          if (bus.ram_gnt) begin
            bus.ram_req <= 1'b0;
            state       <= IDLE;
            if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_W'(1);
          end
        end

        RD_REQ: begin
          if (bus.ram_gnt) begin
            bus.ram_req <= 1'b0;
            state       <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus.ram_rvalid) begin
            bus.tx_data  <= bus.ram_rdata;
            bus.tx_valid <= 1'b1;
            state        <= TX;
            if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: writes, reads, wrap, sequence/overflow errors, reset.
// Inputs change 1ns after the rising edge; outputs are checked at that point.
// Expected values are hand-computed constants.
module tb_spi_ram_ctrl;
  import spi_ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  spi_ram_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one frame for exactly one sampling edge; returns 1ns after that edge
  task automatic send(input logic [1:0] cmd, input logic [7:0] pay);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = {cmd, pay};
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.ram_gnt    = 1'b0;
    bus.ram_rvalid = 1'b0;
    bus.ram_rdata  = '0;
    do_reset();

    // reset state
    check("rst_ram_req", bus.ram_req, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_errs", {bus.err_seq, bus.err_ovf}, 0);

    // 1: write address 0x12, write data 0xAB, grant always
    bus.ram_gnt = 1'b1;
    send(2'b00, 8'h12);
    send(2'b01, 8'hAB);
    check("wr_req", bus.ram_req, 1);
    check("wr_we", bus.ram_we, 1);
    check("wr_addr", bus.ram_addr, 8'h12);
    check("wr_wdata", bus.ram_wdata, 8'hAB);
    check("wr_busy", bus.busy, 1);
    step();
    check("wr_req_one_cycle", bus.ram_req, 0);
    check("wr_idle", bus.busy, 0);
    send(2'b01, 8'hCD);
    check("wr_autoinc_addr", bus.ram_addr, 8'h13);
    step();

    // 2: read address 0x12, read data, grant after 3 waiting cycles, rvalid 2 later
    bus.ram_gnt = 1'b0;
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_req_c%0d", i), bus.ram_req, 1);
      check($sformatf("rd_addr_c%0d", i), bus.ram_addr, 8'h12);
      if (i == 0) check("rd_we", bus.ram_we, 0);
      if (i == 3) bus.ram_gnt = 1'b1;
      step();
    end
    bus.ram_gnt = 1'b0;
    check("rd_req_dropped", bus.ram_req, 0);
    check("rd_wait_busy", bus.busy, 1);
    step();
    check("rd_no_tx_yet", bus.tx_valid, 0);
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 8'hAB;
    step();
    bus.ram_rvalid = 1'b0;
    bus.ram_rdata  = 8'h00;
    check("rd_tx_valid", bus.tx_valid, 1);
    check("rd_tx_data", bus.tx_data, 8'hAB);
    step();
    step();
    check("rd_tx_hold", bus.tx_valid, 1);
    check("rd_tx_data_hold", bus.tx_data, 8'hAB);
    send(2'b00, 8'h55);
    check("tx_release", bus.tx_valid, 0);
    check("tx_release_idle", bus.busy, 0);
    check("tx_no_ovf", bus.err_ovf, 0);

    // 3: read data with no read address after reset
    do_reset();
    send(2'b11, 8'h00);
    check("seq_err", bus.err_seq, 1);
    check("seq_no_req", bus.ram_req, 0);
    check("seq_idle", bus.busy, 0);

    // 4: wrap of the write address
    bus.ram_gnt = 1'b1;
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    check("wrap_addr_ff", bus.ram_addr, 8'hFF);
    step();
    send(2'b01, 8'h22);
    check("wrap_addr_00", bus.ram_addr, 8'h00);
    check("wrap_wdata", bus.ram_wdata, 8'h22);
    step();

    // 5: frame during RD_WAIT is dropped, read completes
    send(2'b10, 8'h40);
    send(2'b11, 8'h00);
    check("ovf_rd_addr", bus.ram_addr, 8'h40);
    step();
    check("ovf_in_wait", bus.ram_req, 0);
    send(2'b00, 8'h77);
    check("ovf_err", bus.err_ovf, 1);
    check("ovf_no_tx", bus.tx_valid, 0);
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 8'h5A;
    step();
    bus.ram_rvalid = 1'b0;
    check("ovf_tx_valid", bus.tx_valid, 1);
    check("ovf_tx_data", bus.tx_data, 8'h5A);
    check("seq_sticky", bus.err_seq, 1);
    // a write-data frame in TX is processed at once; wr_addr was not touched by the dropped frame
    send(2'b01, 8'h33);
    check("tx_frame_req", bus.ram_req, 1);
    check("tx_frame_addr", bus.ram_addr, 8'h01);
    check("tx_frame_clr", bus.tx_valid, 0);
    step();

    // 6: reset while RD_REQ holds ram_req; the incremented read address is 0x41
    bus.ram_gnt = 1'b0;
    send(2'b11, 8'h00);
    check("r6_req", bus.ram_req, 1);
    check("r6_addr", bus.ram_addr, 8'h41);
    #2 rst = 1'b1;
    #1;
    check("r6_async_req", bus.ram_req, 0);
    check("r6_async_busy", bus.busy, 0);
    bus.ram_gnt = 1'b1;
    step();
    rst = 1'b0;
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 8'hEE;
    step();
    bus.ram_rvalid = 1'b0;
    bus.ram_gnt    = 1'b0;
    step();
    check("r6_late_tx", bus.tx_valid, 0);
    check("r6_late_req", bus.ram_req, 0);
    check("r6_errs_clr", {bus.err_seq, bus.err_ovf}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
